kb_ascii_decoder: RTL and testbench

//  Sits between the PS/2 byte receiver and the UART transmitter in the keyboard-to-serial path.

---
 rtl/kb_ascii_decoder_pkg.sv | 32 +++
 rtl/kb_ascii_decoder_if.sv | 28 ++
 rtl/kb_ascii_decoder_fifo.sv | 69 ++++++
 rtl/kb_ascii_decoder.sv | 106 ++++++++++
 tb/tb_kb_ascii_decoder.sv | 231 +++++++++++++++++++++++
 5 files changed

// File: rtl/kb_ascii_decoder_pkg.sv
// Shared constants, FSM state encoding and lookup result type for the keyboard-to-ASCII path.
package kb_ascii_decoder_pkg;

   // Scan-code prefixes
   localparam logic [7:0] KB_BRK    = 8'hF0;
   localparam logic [7:0] KB_EXT    = 8'hE0;

   // Shift make codes (left, right)
   localparam logic [7:0] KB_LSHIFT = 8'h12;
   localparam logic [7:0] KB_RSHIFT = 8'h59;

   // ASCII constants
   localparam logic [7:0] KB_CR     = 8'h0D;
   localparam logic [7:0] KB_SPACE  = 8'h20;

   typedef enum logic [1:0] {
      StIdle   = 2'd0,
      StBrk    = 2'd1,
      StExt    = 2'd2,
      StExtBrk = 2'd3
   } kb_state_e;

   typedef struct packed {
      logic       hit;
      logic [7:0] ch;
   } kb_xlat_t;

   function automatic logic kb_is_shift(input logic [7:0] code);
      return (code == KB_LSHIFT) || (code == KB_RSHIFT);
   endfunction

endpackage

// File: rtl/kb_ascii_decoder_if.sv
// Scan-byte input strobe and ASCII valid/ready output stream of the decoder.
interface kb_ascii_decoder_if;

   logic [7:0] scan_code;
   logic       scan_done_tick;
   logic [7:0] ascii_data;
   logic       ascii_valid;
   logic       ascii_ready;

   // Environment side: PS/2 receiver plus UART transmitter
   modport master (
      output scan_code,
      output scan_done_tick,
      output ascii_ready,
      input  ascii_data,
      input  ascii_valid
   );

   // Decoder side
   modport slave (
      input  scan_code,
      input  scan_done_tick,
      input  ascii_ready,
      output ascii_data,
      output ascii_valid
   );

endinterface

// File: rtl/kb_ascii_decoder_fifo.sv
// Synchronous FIFO with a registered head output; push while full succeeds only alongside a pop.
module kb_ascii_decoder_fifo #(
   parameter int unsigned DW = 8,
   parameter int unsigned AW = 2
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          push,
   input  logic [DW-1:0] din,
   input  logic          pop,
   output logic          full,
   output logic          empty,
   output logic [DW-1:0] dout
);

   localparam int unsigned Depth    = 1 << AW;
   localparam logic [AW:0] DepthCnt = (AW+1)'(Depth);

   logic [DW-1:0] mem_q [Depth];
   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [AW:0]   count_q, count_d;
   logic [DW-1:0] dout_q, dout_d;
   logic          do_push, do_pop;

   assign full    = (count_q == DepthCnt);
   assign empty   = (count_q == '0);
   assign do_pop  = pop && !empty;
   assign do_push = push && (!full || do_pop);
   assign dout    = dout_q;

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      dout_d   = dout_q;
      if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      unique case ({do_push, do_pop})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
      // Head register tracks the next entry; a byte landing in the new head slot bypasses the array
      if (count_d != '0) begin
         if (do_push && (wr_ptr_q == rd_ptr_d)) dout_d = din;
         else                                   dout_d = mem_q[rd_ptr_d];
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         dout_q   <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         dout_q   <= dout_d;
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem_q[wr_ptr_q] <= din;
   end

endmodule

// File: rtl/kb_ascii_decoder.sv
// PS/2 scan-code to ASCII translator: prefix/shift tracking FSM, lookup table and output FIFO.
module kb_ascii_decoder
   import kb_ascii_decoder_pkg::*;
#(
   parameter int unsigned FIFO_AW = 2
) (
   input  logic               clk,
   input  logic               reset,
   kb_ascii_decoder_if.slave  bus,
   output logic               shift_o,
   output logic               overflow
);

   kb_state_e state_q, state_d;
   logic      shift_q, shift_d;
   logic      overflow_q, overflow_d;
   logic      push;
   logic      fifo_full, fifo_empty;
   kb_xlat_t  xlat;

   // Only make codes reach this table; extended keys are never mapped
   function automatic kb_xlat_t kb_lookup(input logic [7:0] code, input logic shift);
      kb_xlat_t r;
      r.hit = 1'b1;
      r.ch  = 8'h00;
      case (code)
         8'h45:   r.ch = 8'h30;
         8'h16:   r.ch = 8'h31;
         8'h1E:   r.ch = 8'h32;
         8'h26:   r.ch = 8'h33;
         8'h25:   r.ch = 8'h34;
         8'h2E:   r.ch = 8'h35;
         8'h36:   r.ch = 8'h36;
         8'h3D:   r.ch = 8'h37;
         8'h3E:   r.ch = 8'h38;
         8'h46:   r.ch = 8'h39;
         8'h1C:   r.ch = shift ? 8'h41 : 8'h61;
         8'h32:   r.ch = shift ? 8'h42 : 8'h62;
         8'h21:   r.ch = shift ? 8'h43 : 8'h63;
         8'h23:   r.ch = shift ? 8'h44 : 8'h64;
         8'h24:   r.ch = shift ? 8'h45 : 8'h65;
         8'h2B:   r.ch = shift ? 8'h46 : 8'h66;
         8'h29:   r.ch = KB_SPACE;
         8'h5A:   r.ch = KB_CR;
         default: r.hit = 1'b0;
      endcase
      return r;
   endfunction

   always_comb begin
      state_d    = state_q;
      shift_d    = shift_q;
      push       = 1'b0;
      xlat       = kb_lookup(bus.scan_code, shift_q);
      if (bus.scan_done_tick) begin
         unique case (state_q)
            StIdle: begin
               if (bus.scan_code == KB_BRK)          state_d = StBrk;
               else if (bus.scan_code == KB_EXT)     state_d = StExt;
               else if (kb_is_shift(bus.scan_code))  shift_d = 1'b1;
               else                                  push    = xlat.hit;
            end
            StBrk: begin
               if (kb_is_shift(bus.scan_code)) shift_d = 1'b0;
               state_d = StIdle;
            end
            StExt:    state_d = (bus.scan_code == KB_BRK) ? StExtBrk : StIdle;
            StExtBrk: state_d = StIdle;
            default:  state_d = StIdle;
         endcase
      end
      // A full FIFO always has a head, so ascii_ready alone means a pop this cycle
      overflow_d = overflow_q | (push & fifo_full & ~bus.ascii_ready);
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q    <= StIdle;
         shift_q    <= 1'b0;
         overflow_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         shift_q    <= shift_d;
         overflow_q <= overflow_d;
      end
   end

   kb_ascii_decoder_fifo #(
      .DW (8),
      .AW (FIFO_AW)
   ) u_fifo (
      .clk   (clk),
      .reset (reset),
      .push  (push),
      .din   (xlat.ch),
      .pop   (bus.ascii_ready),
      .full  (fifo_full),
      .empty (fifo_empty),
      .dout  (bus.ascii_data)
   );

   assign bus.ascii_valid = !fifo_empty;
   assign shift_o         = shift_q;
   assign overflow        = overflow_q;

endmodule

// File: tb/tb_kb_ascii_decoder.sv
// Self-checking bench: queue-based reference model compared every cycle, plus directed literal checks.
module tb_kb_ascii_decoder;

   localparam int Depth = 4;

   logic clk = 1'b0;
   logic reset = 1'b0;
   logic shift_o, overflow;
   logic cmp_en = 1'b0;
   int   checks = 0;
   int   failures = 0;

   kb_ascii_decoder_if bus ();

   kb_ascii_decoder #(
      .FIFO_AW (2)
   ) dut (
      .clk      (clk),
      .reset    (reset),
      .bus      (bus),
      .shift_o  (shift_o),
      .overflow (overflow)
   );

   always #5 clk = ~clk;

   // Reference tables
   logic [7:0] dig_codes [10] = '{8'h45, 8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D, 8'h3E,
                                  8'h46};
   logic [7:0] let_codes [6]  = '{8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B};
   logic [7:0] lc_tab [256];
   bit         mapped [256];
   bit         is_letter [256];

   // Model state
   logic [7:0] mq [$];
   logic [7:0] got [$];
   bit         m_shift, m_ovf, m_brk, m_ext;
   bit         m_pop, m_push;
   int         m_pre;
   logic [7:0] m_code, m_ch;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   always @(posedge clk or negedge reset) begin
      if (!reset) begin
         mq.delete();
         m_shift = 0;
         m_ovf   = 0;
         m_brk   = 0;
         m_ext   = 0;
      end else begin
         m_pre  = mq.size();
         m_pop  = (m_pre > 0) && bus.ascii_ready;
         m_push = 0;
         m_ch   = 8'h00;
         if (bus.scan_done_tick) begin
            m_code = bus.scan_code;
            if (m_ext) begin
               if (m_brk) begin
                  m_ext = 0;
                  m_brk = 0;
               end else if (m_code == 8'hF0) m_brk = 1;
               else m_ext = 0;
            end else if (m_brk) begin
               if (m_code == 8'h12 || m_code == 8'h59) m_shift = 0;
               m_brk = 0;
            end else if (m_code == 8'hF0) m_brk = 1;
            else if (m_code == 8'hE0) m_ext = 1;
            else if (m_code == 8'h12 || m_code == 8'h59) m_shift = 1;
            else if (mapped[m_code]) begin
               m_push = 1;
               m_ch = (is_letter[m_code] && m_shift) ? lc_tab[m_code] - 8'd32 : lc_tab[m_code];
            end
         end
         if (m_pop) void'(mq.pop_front());
         if (m_push) begin
            if (m_pre == Depth && !m_pop) m_ovf = 1;
            else mq.push_back(m_ch);
         end
      end
   end

   always @(posedge clk) begin
      if (reset && bus.ascii_valid && bus.ascii_ready) got.push_back(bus.ascii_data);
   end

   always @(negedge clk) begin
      if (cmp_en) begin
         chk("cyc_valid", {31'd0, bus.ascii_valid}, {31'd0, mq.size() != 0});
         if (mq.size() != 0) chk("cyc_data", {24'd0, bus.ascii_data}, {24'd0, mq[0]});
         chk("cyc_shift", {31'd0, shift_o}, {31'd0, m_shift});
         chk("cyc_overflow", {31'd0, overflow}, {31'd0, m_ovf});
      end
   end

   task automatic send(input logic [7:0] b);
      bus.scan_code      = b;
      bus.scan_done_tick = 1'b1;
      @(posedge clk);
      #1;
      bus.scan_done_tick = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      reset = 1'b0;
      @(negedge clk);
      chk("rst_valid", {31'd0, bus.ascii_valid}, 32'd0);
      chk("rst_data", {24'd0, bus.ascii_data}, 32'd0);
      chk("rst_shift", {31'd0, shift_o}, 32'd0);
      chk("rst_overflow", {31'd0, overflow}, 32'd0);
      @(posedge clk);
      #1;
      @(posedge clk);
      #1;
      reset = 1'b1;
   endtask

   task automatic expect_got(input string name, input logic [7:0] exp [$]);
      chk({name, "_count"}, got.size(), exp.size());
      for (int i = 0; i < exp.size(); i++) begin
         chk($sformatf("%s_byte%0d", name, i), (i < got.size()) ? {24'd0, got[i]} : 32'hFFFF_FFFF,
             {24'd0, exp[i]});
      end
      got.delete();
   endtask

   initial begin
      for (int i = 0; i < 256; i++) begin
         lc_tab[i]    = 8'h00;
         mapped[i]    = 0;
         is_letter[i] = 0;
      end
      for (int i = 0; i < 10; i++) begin
         lc_tab[dig_codes[i]] = 8'h30 + 8'(i);
         mapped[dig_codes[i]] = 1;
      end
      for (int i = 0; i < 6; i++) begin
         lc_tab[let_codes[i]]    = 8'h61 + 8'(i);
         mapped[let_codes[i]]    = 1;
         is_letter[let_codes[i]] = 1;
      end
      lc_tab[8'h29] = 8'h20;
      mapped[8'h29] = 1;
      lc_tab[8'h5A] = 8'h0D;
      mapped[8'h5A] = 1;

      bus.scan_code      = 8'h00;
      bus.scan_done_tick = 1'b0;
      bus.ascii_ready    = 1'b1;
      do_reset();
      cmp_en = 1'b1;

      // 1: make then break of '0'
      send(8'h45); send(8'hF0); send(8'h45);
      idle(4);
      expect_got("t1", '{8'h30});

      // 2: shifted and unshifted 'a'
      send(8'h12);
      chk("t2_shift_set", {31'd0, shift_o}, 32'd1);
      send(8'h1C); send(8'hF0); send(8'h1C); send(8'hF0); send(8'h12);
      chk("t2_shift_clr", {31'd0, shift_o}, 32'd0);
      send(8'h1C);
      idle(4);
      expect_got("t2", '{8'h41, 8'h61});

      // 3: extended make/break discarded, then IDLE decodes normally
      send(8'hE0); send(8'h75); send(8'hE0); send(8'hF0); send(8'h75); send(8'h16);
      idle(3);
      send(8'h45);
      idle(4);
      expect_got("t3", '{8'h31, 8'h30});

      // Typematic repeat, unmapped code, space/enter under shift, all shifted letters
      send(8'h1C); send(8'h1C); send(8'h1C); send(8'h15);
      send(8'h59); send(8'h29); send(8'h5A); send(8'h32); send(8'h21);
      send(8'h23); send(8'h24); send(8'h2B); send(8'hF0); send(8'h59);
      idle(4);
      expect_got("rep", '{8'h61, 8'h61, 8'h61, 8'h20, 8'h0D, 8'h42, 8'h43, 8'h44, 8'h45, 8'h46});

      // 4: overflow with the sink stalled
      bus.ascii_ready = 1'b0;
      send(8'h16); send(8'h1E); send(8'h26); send(8'h25); send(8'h2E);
      chk("t4_valid", {31'd0, bus.ascii_valid}, 32'd1);
      chk("t4_overflow", {31'd0, overflow}, 32'd1);
      bus.ascii_ready = 1'b1;
      idle(6);
      chk("t4_drained", {31'd0, bus.ascii_valid}, 32'd0);
      chk("t4_sticky", {31'd0, overflow}, 32'd1);
      expect_got("t4", '{8'h31, 8'h32, 8'h33, 8'h34});

      // 5: push and pop together while full
      do_reset();
      bus.ascii_ready = 1'b0;
      send(8'h16); send(8'h1E); send(8'h26); send(8'h25);
      chk("t5_no_ovf_fill", {31'd0, overflow}, 32'd0);
      bus.ascii_ready = 1'b1;
      send(8'h2E);
      bus.ascii_ready = 1'b0;
      chk("t5_no_ovf_both", {31'd0, overflow}, 32'd0);
      send(8'h45);
      chk("t5_still_full", {31'd0, overflow}, 32'd1);
      bus.ascii_ready = 1'b1;
      idle(6);
      expect_got("t5", '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35});

      // 6: reset discards a pending break prefix
      send(8'hF0);
      do_reset();
      send(8'h45);
      idle(4);
      expect_got("t6", '{8'h30});

      cmp_en = 1'b0;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
